// File: rtl/mini68k_movem_seq.sv
// MOVEM sequencer: walks a register mask, moving one register per bus transfer via the single RF port.
// Latency: 2 cycles + per register (SCAN + MEM wait + WB on loads); waits indefinitely on mem_ack.
module mini68k_movem_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        dir,
    input  logic        predec,
    input  logic        size,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] final_addr,
    output logic [2:0]  rf_sel,
    output logic        rf_is_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] rem_mask;
    logic        dir_q;
    logic        pd_q;
    logic        size_q;
    logic [31:0] cur_addr;
    logic [3:0]  reg_idx;
    logic [31:0] load_data;
    logic [3:0]  low_idx;
    logic [31:0] step;

    // Priority encoder: lowest set bit of the remaining mask.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rem_mask[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    assign step = size_q ? 32'd4 : 32'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_mask  <= '0;
            dir_q     <= 1'b0;
            pd_q      <= 1'b0;
            size_q    <= 1'b0;
            cur_addr  <= '0;
            reg_idx   <= '0;
            load_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rf_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_mask <= mask;
                        dir_q    <= dir;
                        pd_q     <= predec & ~dir;
                        size_q   <= size;
                        cur_addr <= base_addr;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (rem_mask != 16'h0) begin
                        rem_mask <= rem_mask & ~(16'h1 << low_idx);
                        // Predecrement masks are bit-reversed: bit i names register 15-i.
                        reg_idx  <= pd_q ? (4'd15 - low_idx) : low_idx;
                        if (pd_q) begin
                            cur_addr <= cur_addr - step;
                        end
                        mem_req  <= 1'b1;
                        mem_we   <= ~dir_q;
                        state    <= MEM;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (dir_q) begin
                            load_data <= size_q ? mem_rdata
                                                : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
                            rf_we     <= 1'b1;
                            state     <= WB;
                        end else begin
                            if (!pd_q) begin
                                cur_addr <= cur_addr + step;
                            end
                            state <= SCAN;
                        end
                    end
                end
                WB: begin
                    rf_we    <= 1'b0;
                    cur_addr <= cur_addr + step;
                    state    <= SCAN;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rf_sel     = reg_idx[2:0];
    assign rf_is_addr = reg_idx[3];
    assign rf_wdata   = load_data;
    assign final_addr = cur_addr;
    assign mem_addr   = cur_addr;
    // Store data comes straight from the combinational RF read; zero outside a store cycle.
    assign mem_wdata  = (mem_req && mem_we)
                        ? (size_q ? rf_rdata : {16'h0, rf_rdata[15:0]})
                        : 32'h0;

endmodule

// File: tb/tb_mini68k_movem_seq.sv
// Bench for mini68k_movem_seq: transaction-level MOVEM model with a per-cycle compare process,
// bus/RF responders, directed literal cases and randomized transfers.
module tb_mini68k_movem_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mask;
    logic        dir;
    logic        predec;
    logic        size;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] final_addr;
    logic [2:0]  rf_sel;
    logic        rf_is_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mini68k_movem_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .dir(dir),
        .predec(predec), .size(size), .base_addr(base_addr), .busy(busy),
        .done(done), .final_addr(final_addr), .rf_sel(rf_sel),
        .rf_is_addr(rf_is_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } op_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    int errors;
    int checks;

    logic [31:0] regs      [16];
    logic [31:0] init_regs [16];
    assign rf_rdata = regs[{rf_is_addr, rf_sel}];

    op_t ops[$];
    wr_t wrs[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_wdata[$];
    logic [31:0] obs_rf[$];
    int          obs_cycles[$];

    bit          active;
    bit          pending_pop;
    int          idx;
    int          s0;
    int          sdone;
    int          req_cnt;
    int          last_latency;
    int          rf_we_count;
    logic [31:0] exp_final;
    logic [31:0] last_final;

    int          force_delay;
    bit          force_rdata_en;
    logic [31:0] force_rdata;

    // model scratch
    bit          m_pd;
    logic [31:0] m_step;
    logic [31:0] m_addr;
    logic [31:0] m_rd;
    int          m_reg;
    int          m_total;
    op_t         m_op;
    wr_t         m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process and bus responder, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl", {27'd0, busy, done, rf_we, mem_req, mem_we}, 32'd0);
            chk("reset_data", mem_addr | mem_wdata | rf_wdata | final_addr
                              | {28'd0, rf_is_addr, rf_sel}, 32'd0);
            active      = 1'b0;
            pending_pop = 1'b0;
            req_cnt     = 0;
            ops.delete();
            wrs.delete();
            mem_ack     = 1'b0;
            mem_rdata   = 32'h0;
            for (int i = 0; i < 16; i++) regs[i] = init_regs[i];
        end else begin
            idx++;
            if (pending_pop) begin
                void'(ops.pop_front());
                pending_pop = 1'b0;
                req_cnt     = 0;
            end
            chk("busy", {31'd0, busy}, {31'd0, (active && idx > s0)});
            chk("done", {31'd0, done}, {31'd0, (active && idx == sdone)});
            if (done && active) begin
                chk("final_addr", final_addr, exp_final);
                chk("ops_left", 32'(ops.size()), 32'd0);
                chk("wbs_left", 32'(wrs.size()), 32'd0);
                last_latency = idx - s0;
                last_final   = final_addr;
                active       = 1'b0;
            end
            if (mem_req) begin
                if (ops.size() == 0) begin
                    chk("spurious_mem_req", {31'd0, mem_req}, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, ops[0].addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, ops[0].we});
                    if (ops[0].we) chk("mem_wdata", mem_wdata, ops[0].wdata);
                end
                if (rf_we) chk("rf_we_in_mem", {31'd0, rf_we}, 32'd0);
            end
            if (rf_we) begin
                if (wrs.size() == 0) begin
                    chk("spurious_rf_we", {31'd0, rf_we}, 32'd0);
                end else begin
                    chk("rf_index", {28'd0, rf_is_addr, rf_sel}, {28'd0, wrs[0].idx});
                    chk("rf_wdata", rf_wdata, wrs[0].data);
                    regs[wrs[0].idx] = wrs[0].data;
                    void'(wrs.pop_front());
                end
                obs_rf.push_back(rf_wdata);
                rf_we_count++;
            end
            if (start && !busy) begin
                obs_addr.delete(); obs_wdata.delete(); obs_rf.delete(); obs_cycles.delete();
                rf_we_count = 0;
                m_pd   = predec && !dir;
                m_step = size ? 32'd4 : 32'd2;
                m_addr = base_addr;
                m_total = 0;
                for (int i = 0; i < 16; i++) begin
                    if (mask[i]) begin
                        m_reg = m_pd ? 15 - i : i;
                        if (m_pd) m_addr = m_addr - m_step;
                        m_rd        = force_rdata_en ? force_rdata : $urandom;
                        m_op.addr   = m_addr;
                        m_op.we     = !dir;
                        m_op.wdata  = size ? regs[m_reg] : {16'h0, regs[m_reg][15:0]};
                        m_op.rdata  = m_rd;
                        m_op.delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                        ops.push_back(m_op);
                        if (dir) begin
                            m_wr.idx  = 4'(m_reg);
                            m_wr.data = size ? m_rd : {{16{m_rd[15]}}, m_rd[15:0]};
                            wrs.push_back(m_wr);
                        end
                        if (!m_pd) m_addr = m_addr + m_step;
                        m_total += 2 + m_op.delay + (dir ? 1 : 0);
                    end
                end
                exp_final = m_addr;
                s0        = idx;
                sdone     = idx + 2 + m_total;
                active    = 1'b1;
            end
            if (mem_req && ops.size() > 0) begin
                if (req_cnt >= ops[0].delay) begin
                    mem_ack     = 1'b1;
                    mem_rdata   = ops[0].rdata;
                    pending_pop = 1'b1;
                    obs_addr.push_back(mem_addr);
                    obs_wdata.push_back(mem_wdata);
                    obs_cycles.push_back(req_cnt + 1);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    req_cnt++;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    task automatic run_xfer(input logic [15:0] m, input logic d, input logic p,
                            input logic s, input logic [31:0] b, input bit noise);
        int n;
        n = 0;
        while ((busy || active) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        mask = m; dir = d; predec = p; size = s; base_addr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 2000) begin
            if (!active && !busy) break;
            if (noise && busy && $urandom_range(0, 5) == 0) begin
                start = 1'b1; mask = 16'($urandom); dir = 1'($urandom);
                base_addr = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: busy=%0d active=%0d after %0d cycles", busy, active, n);
        end
    endtask

    initial begin
        int n;
        logic [15:0] rm;
        logic [31:0] rb;
        int r;
        errors = 0; checks = 0; idx = 0; active = 1'b0; pending_pop = 1'b0;
        rst_n = 1'b0; start = 1'b0; mask = '0; dir = 1'b0; predec = 1'b0;
        size = 1'b0; base_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        force_delay = 0; force_rdata_en = 1'b0; force_rdata = '0;
        for (int i = 0; i < 16; i++) init_regs[i] = $urandom;
        init_regs[0]  = 32'h11111111;
        init_regs[8]  = 32'h22222222;
        init_regs[15] = 32'hAAAA1234;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Two-register long store, immediate ack
        run_xfer(16'h0101, 1'b0, 1'b0, 1'b1, 32'h00001000, 1'b0);
        chk("s1_count", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            chk("s1_addr0", obs_addr[0], 32'h00001000);
            chk("s1_data0", obs_wdata[0], 32'h11111111);
            chk("s1_addr1", obs_addr[1], 32'h00001004);
            chk("s1_data1", obs_wdata[1], 32'h22222222);
        end
        chk("s1_final", last_final, 32'h00001008);

        // Single long store, same-cycle ack: start to done in 4 cycles
        run_xfer(16'h0008, 1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0);
        chk("s2_latency", 32'(last_latency), 32'd4);

        // Predecrement word store of A7 then D0
        run_xfer(16'h8001, 1'b0, 1'b1, 1'b0, 32'h00002000, 1'b0);
        chk("pd_count", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            chk("pd_addr0", obs_addr[0], 32'h00001FFE);
            chk("pd_data0", obs_wdata[0], 32'h00001234);
            chk("pd_addr1", obs_addr[1], 32'h00001FFC);
            chk("pd_data1", obs_wdata[1], 32'h00001111);
        end
        chk("pd_final", last_final, 32'h00001FFC);

        // Empty mask
        run_xfer(16'h0000, 1'b0, 1'b0, 1'b1, 32'hABCD0000, 1'b0);
        chk("empty_latency", 32'(last_latency), 32'd2);
        chk("empty_final", last_final, 32'hABCD0000);
        chk("empty_bus", 32'(obs_addr.size() + rf_we_count), 32'd0);

        // Long store wrapping through zero
        run_xfer(16'h0003, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
        chk("wrap_count", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            chk("wrap_addr0", obs_addr[0], 32'hFFFFFFFC);
            chk("wrap_addr1", obs_addr[1], 32'h00000000);
        end
        chk("wrap_final", last_final, 32'h00000004);

        // Word load of D2 with 3-cycle ack delay
        force_delay = 3; force_rdata_en = 1'b1; force_rdata = 32'h00008001;
        run_xfer(16'h0004, 1'b1, 1'b0, 1'b0, 32'h00003000, 1'b0);
        force_rdata_en = 1'b0;
        chk("ld_req_cycles", 32'(obs_cycles.size() > 0 ? obs_cycles[0] : 0), 32'd4);
        chk("ld_rf_data", (obs_rf.size() > 0) ? obs_rf[0] : 32'h0, 32'hFFFF8001);
        chk("ld_rf_pulses", 32'(rf_we_count), 32'd1);
        chk("ld_final", last_final, 32'h00003002);

        // Reset in the middle of a three-register store
        force_delay = 6;
        @(posedge clk); #1;
        mask = 16'h0007; dir = 1'b0; predec = 1'b0; size = 1'b1; base_addr = 32'h4000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rst_busy_drop", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        force_delay = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_idle", {30'd0, busy, done}, 32'd0);
        run_xfer(16'h0101, 1'b0, 1'b0, 1'b1, 32'h00001000, 1'b0);
        chk("rst_new_final", last_final, 32'h00001008);
        chk("rst_new_data", (obs_wdata.size() > 0) ? obs_wdata[0] : 32'h0, 32'h11111111);

        // Randomized transfers with random ack delays and ignored start pulses
        force_delay = -1;
        for (int t = 0; t < 60; t++) begin
            r  = int'($urandom_range(0, 9));
            rm = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            if (r >= 6) rm = rm & 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                             : $urandom;
            run_xfer(rm, 1'($urandom), 1'($urandom), 1'($urandom), rb, 1'b1);
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mini68k_movem_seq.md
MINI68K_MOVEM_SEQ -- requirements
Module: mini68k_movem_seq

Sequences 68k MOVEM transfers: scans a 16-bit register mask and moves each selected D/A register to or from memory through the single register-file port.

Interface
REQ-001 clk  in  1  clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  begin a transfer; sampled only while busy=0.
REQ-004 mask  in  16  register select.
  - Normal mode: bit0..7 = D0..D7, bit8..15 = A0..A7.
  - Predec mode: bit i selects register 15-i.
REQ-005 dir  in  1  0 = registers to memory (store); 1 = memory to registers (load).
REQ-006 predec  in  1  predecrement address mode; honoured only when dir=0, forced to 0 when dir=1.
REQ-007 size  in  1  0 = word (step 2); 1 = long (step 4).
REQ-008 base_addr  in  32  starting effective address.
REQ-009 busy  out  1  high from the cycle after start is accepted through the DONE state.
REQ-010 done  out  1  single-cycle completion pulse.
REQ-011 final_addr  out  32  address after the last transfer, for An writeback; valid while done=1.
REQ-012 rf_sel  out  3  register index; rf_is_addr out 1 selects the A bank.
REQ-013 rf_we  out  1  register-file write enable; rf_wdata out 32 is the write data.
REQ-014 rf_rdata  in  32  combinational register-file read data for rf_sel/rf_is_addr.
REQ-015 mem_req  out  1  bus request; mem_we out 1 marks a write.
REQ-016 mem_addr  out  32, mem_wdata out 32  bus address and write data.
REQ-017 mem_ack  in  1  bus transfer complete; mem_rdata in 32 is the load data.

Function
REQ-018 States SHALL be IDLE, SCAN, MEM, WB, DONE.
REQ-019 IDLE: start=1 latches mask, dir, effective predec, size and base_addr into cur_addr -> SCAN.
REQ-020 SCAN: the lowest set bit of the remaining mask is selected in one cycle.
  - Its bit is cleared and its register index latched.
  - In predec mode, cur_addr -= step.
  - Next state MEM.
  - If no bit remains -> DONE.
REQ-021 MEM: mem_req=1, with mem_addr=cur_addr and mem_we=~dir, all held stable until mem_ack=1.
REQ-022 Store: rf_sel/rf_is_addr drive the latched register.
  - mem_wdata = rf_rdata for long; {16'h0, rf_rdata[15:0]} for word.
REQ-023 Store ack: non-predec cur_addr += step; predec address unchanged; -> SCAN.
REQ-024 Load ack: mem_rdata is captured, sign-extended from bit 15 when size=0 (both banks) -> WB.
REQ-025 WB: rf_we=1 for exactly one cycle with the captured data; cur_addr += step -> SCAN.
REQ-026 DONE: done=1 and final_addr=cur_addr for one cycle -> IDLE.
REQ-027 Address arithmetic SHALL be 32-bit modulo; wrap through 0 or 0xFFFFFFFF is silent.
REQ-028 Empty mask: start -> SCAN -> DONE; done is asserted 2 cycles after the start cycle; no mem_req, no rf_we; final_addr = base_addr.
REQ-029 start while busy=1 SHALL be ignored. mem_ack outside MEM SHALL be ignored.
REQ-030 rf_we SHALL only assert in WB; mem_req SHALL only assert in MEM.
REQ-031 Single-register long store with same-cycle ack: 4 cycles from start to done (IDLE, SCAN, MEM, SCAN, then DONE).

Reset
REQ-032 On rst_n=0, the block SHALL immediately enter IDLE, aborting any transfer.
  - Outputs: busy, done, rf_we, mem_req, mem_we = 0; all address/data outputs = 0.
  - Remaining mask cleared.
REQ-033 After reset release, the first start SHALL behave as a fresh transfer; no aborted transfer is resumed or replayed.

Verification
REQ-034 Store, mask=16'h0101, long, base 0x1000, D0=0x11111111, A0=0x22222222, ack immediate -> writes 0x11111111@0x1000 and 0x22222222@0x1004; final_addr 0x1008.
REQ-035 Predec store, mask=16'h8001 (D0, A7), word, base 0x2000 -> A7 low half @0x1FFE, then D0 low half @0x1FFC; final_addr 0x1FFC.
REQ-036 Load, mask=16'h0004 (D2), word, mem_rdata=0x0000_8001, ack delayed 3 cycles -> mem_req held 4 cycles with stable address; D2=0xFFFF8001; one rf_we pulse.
REQ-037 Empty mask, base 0xABCD0000 -> done 2 cycles after start; final_addr 0xABCD0000; no bus/rf activity.
REQ-038 rst_n low mid-MEM of a 3-register store -> mem_req/busy drop immediately; after release, idle with no spurious done; new start works.
REQ-039 Long store at base 0xFFFFFFFC, mask=16'h0003 -> addresses 0xFFFFFFFC then 0x00000000; final_addr 0x00000004.
